// File: rtl/hcheck_sink_pkg.sv
// hcheck_sink_pkg: shared channel field widths and sink constants
//   No ports. Provides the default address/data/redundancy widths used by
//   hlang message sources and sinks, and the width of the ack delay counter.
package hcheck_sink_pkg;
    localparam int NS_ADDRESS_SIZE = 6;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;
    localparam int DLY_W           = 8;
endpackage

// File: rtl/hcheck_sink_redun.sv
// hredun_calc: combinational redundancy fold of a message vector
//   i_vec  in  W    {src,dst,dat}, src in the MSBs
//   o_red  out RSZ  XOR of all RSZ-bit slices after zero-extending i_vec at the top
module hredun_calc #(
    parameter int W   = 20,
    parameter int RSZ = 4
)(
    input  logic [W-1:0]   i_vec,
    output logic [RSZ-1:0] o_red
);
    localparam int N = (W + RSZ - 1) / RSZ;
    logic [N*RSZ-1:0] w_pad;
    assign w_pad = (N*RSZ)'(i_vec);
    always_comb begin
        o_red = '0;
        for (int k = 0; k < N; k++) o_red = o_red ^ w_pad[k*RSZ +: RSZ];
    end
endmodule

// File: rtl/hcheck_sink.sv
// hcheck_sink: terminal consumer for one two-phase req/ack hlang message channel
//   gch_clk       in   clock, rising edge
//   gch_reset     in   asynchronous active-low reset
//   gch_ready     out  high once initialised
//   rcv0_req_in   in   request toggle from sender
//   rcv0_ack_out  out  acknowledge toggle to sender
//   rcv0_src/dst/dat/red  in  message fields, sampled only at the capture edge
//   rcv_count     out  saturating count of acknowledged messages
//   err_count     out  saturating count of acknowledged erroneous messages
//   err_flag      out  sticky error seen
//   last_dat      out  data of the most recently captured message
// Optional build macro HCHECK_SINK_STOP_ON_ERR_EN: halt after acking an erroneous message.
module hcheck_sink
    import hcheck_sink_pkg::*;
#(
    parameter int             ASZ     = NS_ADDRESS_SIZE,
    parameter int             DSZ     = NS_DATA_SIZE,
    parameter int             RSZ     = NS_REDUN_SIZE,
    parameter logic [ASZ-1:0] MY_ADDR = '0,
    parameter int             ACK_DLY = 0,
    parameter int             CSZ     = 16
)(
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           rcv0_req_in,
    output logic           rcv0_ack_out,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    output logic [CSZ-1:0] rcv_count,
    output logic [CSZ-1:0] err_count,
    output logic           err_flag,
    output logic [DSZ-1:0] last_dat
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_HALT} state_t;
    state_t           r_state;
    logic             r_ready;
    logic             r_ack;
    logic             r_bad;
    logic             r_flag;
    logic [CSZ-1:0]   r_rcv;
    logic [CSZ-1:0]   r_err;
    logic [DSZ-1:0]   r_last;
    logic [DLY_W-1:0] r_dly;
    logic [RSZ-1:0]   w_red;
    logic             w_pend;
    logic             w_bad;
    hredun_calc #(.W(2*ASZ+DSZ), .RSZ(RSZ)) u_red (
        .i_vec ({rcv0_src, rcv0_dst, rcv0_dat}),
        .o_red (w_red)
    );
    assign w_pend = rcv0_req_in != r_ack;
    assign w_bad  = (rcv0_dst != MY_ADDR) || (rcv0_red != w_red);
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            r_state <= S_INIT;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_bad   <= 1'b0;
            r_flag  <= 1'b0;
            r_rcv   <= '0;
            r_err   <= '0;
            r_last  <= '0;
            r_dly   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_IDLE: if (w_pend) begin
                    r_last  <= rcv0_dat;
                    r_bad   <= w_bad;
                    r_dly   <= DLY_W'(ACK_DLY);
                    r_state <= S_WAIT;
                end
                S_WAIT: if (r_dly == '0) begin
                    r_ack <= ~r_ack;
                    r_rcv <= (&r_rcv) ? r_rcv : r_rcv + 1'b1;
                    // err_count can only move together with rcv_count, so it never overtakes it
                    if (r_bad && !(&r_err)) r_err <= r_err + 1'b1;
                    if (r_bad) r_flag <= 1'b1;
`ifdef HCHECK_SINK_STOP_ON_ERR_EN
                    r_state <= r_bad ? S_HALT : S_IDLE;
`else
                    r_state <= S_IDLE;
`endif
                end else begin
                    r_dly <= r_dly - 1'b1;
                end
                default: r_state <= r_state;
            endcase
        end
    end
    assign gch_ready    = r_ready;
    assign rcv0_ack_out = r_ack;
    assign rcv_count    = r_rcv;
    assign err_count    = r_err;
    assign err_flag     = r_flag;
    assign last_dat     = r_last;
endmodule

// File: tb/tb_hcheck_sink.sv
// tb_hcheck_sink: directed self-checking bench for hcheck_sink (ASZ=6 DSZ=8 RSZ=4 MY_ADDR=5 ACK_DLY=2 CSZ=3)
module tb_hcheck_sink;
    logic       gch_clk = 1'b0;
    logic       gch_reset = 1'b0;
    logic       gch_ready;
    logic       rcv0_req_in = 1'b0;
    logic       rcv0_ack_out;
    logic [5:0] rcv0_src = 6'd1;
    logic [5:0] rcv0_dst = 6'd5;
    logic [7:0] rcv0_dat = 8'hA3;
    logic [3:0] rcv0_red = 4'h8;
    logic [2:0] rcv_count;
    logic [2:0] err_count;
    logic       err_flag;
    logic [7:0] last_dat;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    hcheck_sink #(
        .ASZ(6), .DSZ(8), .RSZ(4), .MY_ADDR(6'd5), .ACK_DLY(2), .CSZ(3)
    ) dut (
        .gch_clk      (gch_clk),
        .gch_reset    (gch_reset),
        .gch_ready    (gch_ready),
        .rcv0_req_in  (rcv0_req_in),
        .rcv0_ack_out (rcv0_ack_out),
        .rcv0_src     (rcv0_src),
        .rcv0_dst     (rcv0_dst),
        .rcv0_dat     (rcv0_dat),
        .rcv0_red     (rcv0_red),
        .rcv_count    (rcv_count),
        .err_count    (err_count),
        .err_flag     (err_flag),
        .last_dat     (last_dat)
    );

    always #5 gch_clk = ~gch_clk;
    always @(posedge gch_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] red_of(input logic [5:0] s, input logic [5:0] d, input logic [7:0] v);
        logic [19:0] x;
        x = {s, d, v};
        return x[19:16] ^ x[15:12] ^ x[11:8] ^ x[7:4] ^ x[3:0];
    endfunction

    task automatic reset_dut();
        @(negedge gch_clk);
        gch_reset = 1'b0;
        rcv0_req_in = 1'b0;
        @(negedge gch_clk);
        @(negedge gch_clk);
        gch_reset = 1'b1;
        @(negedge gch_clk);
    endtask

    // Called at a negedge; returns edges from the capture edge to the ack edge, 99 on timeout.
    task automatic send(input logic [5:0] s, input logic [5:0] d, input logic [7:0] v,
                        input logic [3:0] r, output int edges);
        rcv0_src = s;
        rcv0_dst = d;
        rcv0_dat = v;
        rcv0_red = r;
        rcv0_req_in = ~rcv0_req_in;
        edges = 99;
        for (int i = 0; i < 20; i++) begin
            @(negedge gch_clk);
            if (i == 0) begin
                rcv0_src = 6'($urandom);
                rcv0_dst = 6'($urandom);
                rcv0_dat = 8'($urandom);
                rcv0_red = 4'($urandom);
            end
            if (rcv0_ack_out == rcv0_req_in) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int prev;
        int acks;
        logic [7:0] v;
        repeat (2) @(negedge gch_clk);
        chk("rst_ready", gch_ready, 0);
        chk("rst_ack", rcv0_ack_out, 0);
        chk("rst_rcv", rcv_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_flag", err_flag, 0);
        chk("rst_last", last_dat, 0);

        rcv0_req_in = 1'b1;
        gch_reset = 1'b1;
        @(negedge gch_clk);
        chk("init_ready", gch_ready, 1);
        chk("init_nocap", last_dat, 0);
        @(negedge gch_clk);
        chk("init_cap", last_dat, 8'hA3);
        chk("init_ack0", rcv0_ack_out, 0);
        repeat (2) @(negedge gch_clk);
        chk("init_ack_early", rcv0_ack_out, 0);
        @(negedge gch_clk);
        chk("init_ack", rcv0_ack_out, 1);
        chk("init_rcv", rcv_count, 1);

        reset_dut();
        send(6'd1, 6'd5, 8'hA3, 4'h8, e);
        chk("good_lat", e, 3);
        chk("good_rcv", rcv_count, 1);
        chk("good_err", err_count, 0);
        chk("good_flag", err_flag, 0);
        chk("good_last", last_dat, 8'hA3);
        send(6'd1, 6'd5, 8'hA3, 4'h9, e);
        chk("badred_lat", e, 3);
        chk("badred_rcv", rcv_count, 2);
        chk("badred_err", err_count, 1);
        chk("badred_flag", err_flag, 1);

        reset_dut();
        send(6'd1, 6'd4, 8'hA3, 4'h9, e);
        chk("dst_lat", e, 3);
        chk("dst_rcv", rcv_count, 1);
        chk("dst_err", err_count, 1);
        chk("dst_flag", err_flag, 1);
        send(6'd1, 6'd5, 8'hA3, 4'h8, e);
`ifdef HCHECK_SINK_STOP_ON_ERR_EN
        chk("halt_noack", e, 99);
        chk("halt_rcv", rcv_count, 1);
`else
        chk("after_err_lat", e, 3);
        chk("after_err_rcv", rcv_count, 2);
        chk("after_err_err", err_count, 1);
`endif

        reset_dut();
        prev = 0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            v = 8'h10 + 8'(i * 7);
            send(6'd1, 6'd5, v, red_of(6'd1, 6'd5, v), e);
            chk("b2b_lat", e, 3);
            chk("b2b_dat", last_dat, v);
            if (i > 0) chk("b2b_gap", cyc - prev, 4);
            prev = cyc;
            if (e != 99) acks++;
        end
        chk("b2b_acks", acks, 10);
        chk("sat_rcv", rcv_count, 7);
        chk("sat_err", err_count, 0);
        chk("sat_flag", err_flag, 0);

        send(6'd1, 6'd5, 8'hA3, 4'h8, e);
        chk("pre_rst_ack", rcv0_ack_out, 1);
        chk("pre_rst_rcv", rcv_count, 7);
        rcv0_req_in = 1'b0;
        @(negedge gch_clk);
        #2 gch_reset = 1'b0;
        #1;
        chk("mid_rst_ack", rcv0_ack_out, 0);
        chk("mid_rst_rcv", rcv_count, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_ready", gch_ready, 0);
        chk("mid_rst_last", last_dat, 0);
        @(negedge gch_clk);
        gch_reset = 1'b1;
        @(negedge gch_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
